// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared types and constants for the microwave controller
//
// Purpose: state encoding, power-level constants and BCD digit width shared
// by microwave_ctrl and bcd_down_counter.
// Ports: none (package).

package micro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int POWER_MAX    = 10;
  localparam int POWER_PHASES = 10;
  localparam int BCD_W        = 4;

  // Out-of-range requests (0 or above the maximum) mean full power.
  function automatic logic [3:0] clamp_power(input logic [3:0] lvl);
    if (lvl == 4'd0 || lvl > 4'(POWER_MAX)) begin
      return 4'(POWER_MAX);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - packed BCD time register with shift-in and minute/second borrow
//
// Purpose: holds the cooking time as DIGITS packed BCD digits (digit 0 = sec
// ones, digit 1 = sec tens, digits 2+ = minutes). Decrement borrows 0->9 on
// every digit except sec tens, which borrows 0->5.
// Ports:
//   clock, clearn       clock and asynchronous active-low reset
//   load, load_val      parallel load (priority below clear)
//   shift, shift_digit  shift time up one digit, new digit into digit 0
//   clear               synchronous clear to zero (highest priority)
//   dec                 decrement by one second
//   bcd                 current packed BCD value
//   is_zero             bcd == 0

module bcd_down_counter
  import micro_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clock,
  input  logic                      clearn,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_val,
  input  logic [3:0]                shift_digit,
  input  logic                      shift,
  input  logic                      clear,
  input  logic                      dec,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      is_zero
);

  logic [BCD_W*DIGITS-1:0] dec_val;
  logic                    borrow;

  // Ripple borrow from digit 0 upward; a digit only changes while the borrow
  // is still propagating into it. Entered sec tens above 5 simply count down
  // in decimal because only a zero digit takes the base-6 wrap.
  always_comb begin
    dec_val = bcd;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (bcd[i*BCD_W +: BCD_W] == 4'd0) begin
          dec_val[i*BCD_W +: BCD_W] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          dec_val[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      bcd <= '0;
    end else if (clear) begin
      bcd <= '0;
    end else if (load) begin
      bcd <= load_val;
    end else if (shift) begin
      bcd <= {bcd[BCD_W*(DIGITS-1)-1:0], shift_digit};
    end else if (dec) begin
      bcd <= dec_val;
    end
  end

  assign is_zero = (bcd == '0);

endmodule

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave cooking controller: keypad entry, start/stop/door FSM, countdown, power duty cycle
//
// Purpose: top level holding the IDLE/COOK/PAUSE/DONE FSM, button edge
// detectors, the seconds prescaler and (optionally) the power phase counter.
// Optional feature macro: MICROWAVE_POWER_LEVEL_EN enables duty-cycled power
// levels; without it the magnetron is fully on whenever cooking.
// Ports:
//   clock, clearn            clock and asynchronous active-low reset
//   startn, stopn            active-low buttons, act on falling edge
//   door_closed              1 = door closed
//   key_valid, key_digit     keypad strobe and digit (values > 9 ignored)
//   power_set, power_level   power strobe and level 1..10
//   time_bcd                 packed BCD time, digit 0 = sec ones
//   mag_on                   magnetron enable (door term combinational)
//   done                     high while in DONE
//   state                    0 IDLE, 1 COOK, 2 PAUSE, 3 DONE

module microwave_ctrl
  import micro_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int CLK_PER_SEC = 10,
  parameter int BEEP_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    clearn,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    door_closed,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    power_set,
  input  logic [3:0]              power_level,
  output logic [BCD_W*DIGITS-1:0] time_bcd,
  output logic                    mag_on,
  output logic                    done,
  output logic [1:0]              state
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_COOK  = ST_COOK;
  localparam logic [1:0] S_PAUSE = ST_PAUSE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [1:0]    st_q, st_d;
  logic          start_q, stop_q;
  logic          start_edge, stop_edge;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          cnt_clear, cnt_shift, cnt_dec;
  logic          is_zero, time_is_one, presc_wrap, power_gate;

  assign start_edge  = start_q & ~startn;
  assign stop_edge   = stop_q & ~stopn;
  assign presc_wrap  = (presc_q == PW'(CLK_PER_SEC - 1));
  // The next decrement reaches zero exactly when only sec ones is 1.
  assign time_is_one = (time_bcd == (BCD_W*DIGITS)'(1));

  bcd_down_counter #(
    .DIGITS (DIGITS)
  ) u_time (
    .clock       (clock),
    .clearn      (clearn),
    .load        (1'b0),
    .load_val    ('0),
    .shift_digit (key_digit),
    .shift       (cnt_shift),
    .clear       (cnt_clear),
    .dec         (cnt_dec),
    .bcd         (time_bcd),
    .is_zero     (is_zero)
  );

  // Stop is checked first in every state so it beats a simultaneous start;
  // door-open is checked before the prescaler so it beats a decrement.
  always_comb begin
    st_d      = st_q;
    presc_d   = presc_q;
    beep_d    = beep_q;
    cnt_clear = 1'b0;
    cnt_shift = 1'b0;
    cnt_dec   = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (stop_edge) begin
          cnt_clear = 1'b1;
        end else if (start_edge && door_closed && !is_zero) begin
          st_d    = S_COOK;
          presc_d = '0;
        end else if (key_valid && key_digit <= 4'd9) begin
          cnt_shift = 1'b1;
        end
      end
      S_COOK: begin
        if (stop_edge || !door_closed) begin
          st_d = S_PAUSE;
        end else if (presc_wrap) begin
          presc_d = '0;
          cnt_dec = 1'b1;
          if (time_is_one) begin
            st_d   = S_DONE;
            beep_d = '0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (stop_edge) begin
          st_d      = S_IDLE;
          cnt_clear = 1'b1;
        end else if (start_edge && door_closed) begin
          st_d = S_COOK;
        end
      end
      default: begin
        if (stop_edge || beep_q == BW'(BEEP_CYCLES - 1)) begin
          st_d = S_IDLE;
        end else begin
          beep_d = beep_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      st_q    <= S_IDLE;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      presc_q <= '0;
      beep_q  <= '0;
    end else begin
      st_q    <= st_d;
      start_q <= startn;
      stop_q  <= stopn;
      presc_q <= presc_d;
      beep_q  <= beep_d;
    end
  end

`ifdef MICROWAVE_POWER_LEVEL_EN
  logic [3:0] power_q;
  logic [3:0] phase_q;

  // Phase runs every clock while cooking, holds in PAUSE, and restarts only
  // on a fresh cook from IDLE so a resume keeps the duty pattern aligned.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      power_q <= 4'(POWER_MAX);
      phase_q <= '0;
    end else begin
      if (st_q == S_IDLE && power_set) begin
        power_q <= clamp_power(power_level);
      end
      if (st_q == S_IDLE && st_d == S_COOK) begin
        phase_q <= '0;
      end else if (st_q == S_COOK) begin
        phase_q <= (phase_q == 4'(POWER_PHASES - 1)) ? 4'd0 : phase_q + 4'd1;
      end
    end
  end

  assign power_gate = (phase_q < power_q);
`else
  logic unused_power;
  assign unused_power = ^{power_set, power_level};
  assign power_gate   = 1'b1;
`endif

  assign mag_on = (st_q == S_COOK) & power_gate & door_closed;
  assign done   = (st_q == S_DONE);
  assign state  = st_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb/tb_microwave_ctrl.sv - self-checking bench for microwave_ctrl with a behavioural reference model

module tb_microwave_ctrl;

  localparam int DIGITS = 4;
  localparam int CPS    = 10;
  localparam int BEEP   = 4;
  localparam int MODV   = 10 ** DIGITS;
`ifdef MICROWAVE_POWER_LEVEL_EN
  localparam bit PWR_EN = 1'b1;
`else
  localparam bit PWR_EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                clearn, startn, stopn, door_closed, key_valid, power_set;
  logic [3:0]          key_digit, power_level;
  logic [4*DIGITS-1:0] time_bcd;
  logic                mag_on, done;
  logic [1:0]          state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time held as the plain decimal number shown on the display.
  int m_state, m_time, m_presc, m_phase, m_beep, m_power;
  bit m_ps, m_pp;

  microwave_ctrl #(
    .DIGITS      (DIGITS),
    .CLK_PER_SEC (CPS),
    .BEEP_CYCLES (BEEP)
  ) dut (
    .clock       (clock),
    .clearn      (clearn),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .power_set   (power_set),
    .power_level (power_level),
    .time_bcd    (time_bcd),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int t);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((t / (10 ** i)) % 10);
    end
    return r;
  endfunction

  // One second less on a min:sec display: seconds field 00 borrows a minute.
  function automatic int sec_down(input int t);
    if (t % 100 == 0) return t - 100 + 59;
    return t - 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_time = 0; m_presc = 0; m_phase = 0; m_beep = 0;
    m_power = 10; m_ps = 1'b1; m_pp = 1'b1;
  endtask

  task automatic model_step();
    bit se, pe;
    se = m_ps && !startn;
    pe = m_pp && !stopn;
    case (m_state)
      0: begin
        if (power_set) m_power = (power_level == 0 || power_level > 10) ? 10 : int'(power_level);
        if (pe) m_time = 0;
        else if (se && door_closed && m_time != 0) begin
          m_state = 1; m_presc = 0; m_phase = 0;
        end else if (key_valid && key_digit <= 9) m_time = (m_time * 10 + int'(key_digit)) % MODV;
      end
      1: begin
        m_phase = (m_phase + 1) % 10;
        if (pe || !door_closed) m_state = 2;
        else if (m_presc == CPS - 1) begin
          m_presc = 0;
          m_time  = sec_down(m_time);
          if (m_time == 0) begin m_state = 3; m_beep = 0; end
        end else m_presc++;
      end
      2: begin
        if (pe) begin m_state = 0; m_time = 0; end
        else if (se && door_closed) m_state = 1;
      end
      default: begin
        if (pe || m_beep == BEEP - 1) m_state = 0;
        else m_beep++;
      end
    endcase
    m_ps = startn;
    m_pp = stopn;
  endtask

  task automatic check_outputs();
    bit exp_mag;
    exp_mag = (m_state == 1) && door_closed && (!PWR_EN || m_phase < m_power);
    chk("state", 32'(state), 32'(m_state));
    chk("time_bcd", 32'(time_bcd), to_bcd(m_time));
    chk("done", 32'(done), 32'(m_state == 3));
    chk("mag_on", 32'(mag_on), 32'(exp_mag));
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic key(input int d);
    key_valid = 1'b1; key_digit = 4'(d);
    step();
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    startn = 1'b0; step(); startn = 1'b1; step();
  endtask

  task automatic press_stop();
    stopn = 1'b0; step(); stopn = 1'b1; step();
  endtask

  initial begin
    int k, cnt;
    clearn = 1'b0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0; power_set = 1'b0; power_level = 4'd0;
    model_reset();
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_time", 32'(time_bcd), 32'd0);
    chk("rst_mag", 32'(mag_on), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #4 clearn = 1'b1;

    // Key entry, first decrement, run to DONE
    key(1); key(3); key(0);
    chk("entry_0130", 32'(time_bcd), 32'h0130);
    press_start();
    chk("cook_state", 32'(state), 32'd1);
    steps(8);
    chk("pre_dec", 32'(time_bcd), 32'h0130);
    step();
    chk("first_dec", 32'(time_bcd), 32'h0129);
    k = 0;
    while (state != 2'd3 && k < 2000) begin step(); k++; end
    chk("reach_done", 32'(state), 32'd3);
    cnt = 0;
    while (done && cnt < 20) begin step(); cnt++; end
    chk("done_len", 32'(cnt), 32'(BEEP));
    chk("after_done", 32'(state), 32'd0);

    // Borrow across minute and the 0:99 case
    key(1); key(0); key(0);
    press_start();
    steps(9);
    chk("borrow_0059", 32'(time_bcd), 32'h0059);
    press_stop(); press_stop();
    chk("cancel_time", 32'(time_bcd), 32'd0);
    key(9); key(9);
    press_start();
    steps(9);
    chk("dec_0098", 32'(time_bcd), 32'h0098);
    steps(80);
    chk("dec_0090", 32'(time_bcd), 32'h0090);
    steps(10);
    chk("dec_0089", 32'(time_bcd), 32'h0089);
    press_stop(); press_stop();

    // Door open mid-cook, resume without losing a second
    key(5);
    press_start();
    steps(5);
    door_closed = 1'b0;
    #1;
    chk("door_mag", 32'(mag_on), 32'd0);
    step();
    chk("door_pause", 32'(state), 32'd2);
    steps(20);
    chk("pause_frozen", 32'(time_bcd), 32'h0005);
    door_closed = 1'b1;
    press_start();
    steps(2);
    chk("resume_hold", 32'(time_bcd), 32'h0005);
    step();
    chk("resume_dec", 32'(time_bcd), 32'h0004);
    press_stop(); press_stop();
    chk("pause_stop", 32'(state), 32'd0);

    // Dropped starts, stop beats start
    press_start();
    chk("start_zero", 32'(state), 32'd0);
    key(7);
    door_closed = 1'b0;
    press_start();
    chk("start_door", 32'(state), 32'd0);
    door_closed = 1'b1;
    step();
    chk("not_remembered", 32'(state), 32'd0);
    startn = 1'b0; stopn = 1'b0;
    step();
    chk("stop_wins", 32'(state), 32'd0);
    chk("stop_wins_t", 32'(time_bcd), 32'd0);
    startn = 1'b1; stopn = 1'b1;
    step();

    // Power duty cycle
    power_set = 1'b1; power_level = 4'd3; step(); power_set = 1'b0;
    key(2);
    press_start();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(mag_on); end
    chk("duty_3", 32'(cnt), PWR_EN ? 32'd3 : 32'd10);
    press_stop(); press_stop();
    power_set = 1'b1; power_level = 4'd0; step(); power_set = 1'b0;
    key(2);
    press_start();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(mag_on); end
    chk("duty_clamp", 32'(cnt), 32'd10);
    press_stop(); press_stop();

    // Asynchronous reset mid-cook
    power_set = 1'b1; power_level = 4'd4; step(); power_set = 1'b0;
    key(3);
    press_start();
    steps(4);
    #2 clearn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_time", 32'(time_bcd), 32'd0);
    chk("arst_mag", 32'(mag_on), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    model_reset();
    #1 clearn = 1'b1;
    key(2);
    press_start();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(mag_on); end
    chk("arst_power10", 32'(cnt), 32'd10);
    press_stop(); press_stop();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      door_closed = ($urandom_range(0, 9) != 0);
      startn      = ($urandom_range(0, 9) != 0);
      stopn       = ($urandom_range(0, 29) != 0);
      key_valid   = ($urandom_range(0, 4) == 0);
      key_digit   = 4'($urandom_range(0, 15));
      power_set   = ($urandom_range(0, 9) == 0);
      power_level = 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Parametrised cooking controller for the microwave. It merges keypad time entry, start/stop/door sequencing and the countdown timer into one clocked block, and adds three things the current design lacks: a configurable digit count, pause/resume, and duty-cycled power levels. It drives the BCD-to-7-segment decoder with packed BCD digits and drives the magnetron enable directly.

## Interface
- DIGITS, default 4: number of BCD time digits, least significant first. Digit 0 is sec ones, digit 1 is sec tens, digits 2 and up are minutes. Legal range 3–6.
- CLK_PER_SEC, default 10: clock cycles per countdown second. Minimum 2.
- BEEP_CYCLES, default 4: number of clocks spent in DONE.
- clock  in  1  sole clock, rising edge.
- clearn  in  1  reset, asynchronous, active-low.
- startn  in  1  start button, active-low; acts on its falling edge.
- stopn  in  1  stop/cancel button, active-low; acts on its falling edge.
- door_closed  in  1  1 = door closed.
- key_valid  in  1  one-cycle strobe qualifying key_digit.
- key_digit  in  4  entered digit. Values above 9 are ignored.
- power_set  in  1  one-cycle strobe qualifying power_level.
- power_level  in  4  requested power level, 1..10.
- time_bcd  out  4*DIGITS  remaining or entered time, packed BCD.
- mag_on  out  1  magnetron enable.
- done  out  1  high while in DONE.
- state  out  2  0 IDLE, 1 COOK, 2 PAUSE, 3 DONE.

## Operation
- Reset values:
  - state IDLE, time_bcd 0, mag_on 0, done 0.
  - Power register 10, prescaler 0, phase counter 0.
  - startn/stopn edge registers = 1.
- Edge detection: a button edge is "previous sample 1, current sample 0". Both buttons are sampled every clock.
- IDLE:
  - key_valid with a digit ≤9: time shifts up one digit, the new digit enters digit 0, and the top digit is discarded.
  - power_set: a value of 0 or above 10 clamps to 10.
  - start edge with door_closed=1 and time≠0: go to COOK. Prescaler and phase counter clear.
  - stop edge: time clears to 0.
- COOK:
  - Keys and power_set are ignored.
  - When the prescaler reaches CLK_PER_SEC-1, it wraps and time decrements by one.
  - Decrement rules: sec ones borrow 0→9; sec tens borrow 0→5; each minute digit borrows 0→9.
  - A decrement that produces 0 goes to DONE on the same edge.
  - door_closed=0 or a stop edge goes to PAUSE. The prescaler value is held.
- PAUSE:
  - Start edge with door_closed=1: back to COOK, prescaler resumes from its held value.
  - Stop edge: go to IDLE with time cleared.
  - Keys are ignored.
- DONE:
  - done=1.
  - After BEEP_CYCLES clocks, or on a stop edge, go to IDLE. Time stays 0.
- Simultaneous events:
  - Stop beats start.
  - Door-open beats a decrement, so the time is not changed on that edge.
  - A start edge with the door open, or with time=0, is dropped; it is not remembered.
- Entered seconds tens may exceed 5. For example 0:99 counts 99, 98 … 90, 89 in decimal.
- An asynchronous reset at any point returns every output to its reset value immediately.

## Timing
- State, time_bcd and done are registered.
- mag_on is asserted on the same rising edge that samples the qualifying start edge.
- mag_on = (state==COOK) & power gate & door_closed. The door_closed term is combinational, so opening the door drops mag_on with no clock delay.
- First decrement happens CLK_PER_SEC clocks after entering COOK from IDLE.
- mag_on falls on the edge where time reaches 0.
- done is high for exactly BEEP_CYCLES consecutive clocks, unless a stop edge cuts it short.
- Key entry latency: time_bcd updates on the edge that samples key_valid.

## Configuration
- MICROWAVE_POWER_LEVEL_EN defined:
  - A phase counter runs 0..9 every clock in COOK.
  - Power gate = (phase < power register), so level L gives L of every 10 cycles on. Level 10 is always on.
  - The phase counter holds in PAUSE and clears on entry to COOK from IDLE.
- MICROWAVE_POWER_LEVEL_EN undefined:
  - Power gate is constant 1.
  - power_set and power_level are ignored; the ports remain.

## Structure
- Package micro_pkg holds:
  - the state encoding, as a 2-bit enum;
  - POWER_MAX = 10 and POWER_PHASES = 10;
  - BCD digit width 4.
- One sub-module, bcd_down_counter:
  - Parametrised by DIGITS.
  - Inputs: load value, shift-in digit, shift, clear, decrement.
  - Outputs: packed BCD and is_zero.
  - Implements the base-6 borrow on digit 1.
- The top level holds the FSM, edge detectors, prescaler and power phase counter.

## Test plan
- Key entry: keys 1,3,0 then start, door closed → time_bcd 0x0130; first decrement to 0x0129 after 10 clocks. Run to 0 → DONE, done high 4 clocks, then IDLE.
- Borrow: enter 1,0,0 (1:00) → decrements to 0x0059; enter 9,9 → counts to 0x0090, then 0x0089.
- Door: open the door mid-COOK → mag_on 0 in the same cycle, state PAUSE, time frozen. Close the door and press start → COOK resumes, no lost or extra second.
- Dropped starts and cancel: start with the door open or time 0 → stays IDLE. Stop in PAUSE → IDLE, time 0. Start and stop edges in the same cycle → stop wins.
- Power (with macro): power_level 3, cook → mag_on high 3 of each 10 clocks. power_level 0 → clamped to 10, always on.
- Reset: assert clearn mid-COOK → all outputs 0, power register 10, state IDLE, with no clock edge needed.
